// File: rtl/pixel_in_buffer_pkg.sv
// Shared definitions for the pixel input buffer: FSM state encoding,
// default geometry, lane/component counts and address width.
package pixel_in_buffer_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FILL  = 2'd1,
      S_FULL  = 2'd2,
      S_DRAIN = 2'd3
   } pb_state_e;

   localparam int PB_DEPTH_DEF  = 192;
   localparam int PB_PIXELS_DEF = 64;
   localparam int PB_LANES      = 4;
   localparam int PB_COMPS      = 3;
   localparam int PB_AW         = 8;

endpackage

// File: rtl/pixel_byte_ram.sv
// Byte array for one RGB tile: 4 byte write ports, 3 registered read ports.
// Ports: clk, rst_n (sync, active-low, read regs only), we[3:0] lane enables
//   (already range-qualified), waddr/wdata packed per lane, re, raddr packed
//   {B,G,R}, rdata packed {B,G,R}.
// Build option PIXEL_IN_BUFFER_BYPASS_EN: write-first on same-cycle collisions.
module pixel_byte_ram
   import pixel_in_buffer_pkg::*;
#(
   parameter int P_DEPTH = PB_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  we,
   input  logic [31:0] waddr,
   input  logic [31:0] wdata,
   input  logic        re,
   input  logic [23:0] raddr,
   output logic [23:0] rdata
);

   localparam logic [8:0] DEPTH_L = 9'(P_DEPTH);

   logic [7:0]  mem_q [P_DEPTH];
   logic [23:0] rdata_d;
   logic [23:0] rdata_q;

   // Contents are deliberately not reset; a higher lane wins on a
   // same-address collision between lanes.
   always_ff @(posedge clk) begin
      for (int k = 0; k < PB_LANES; k++) begin
         if (we[k]) mem_q[waddr[8*k +: 8]] <= wdata[8*k +: 8];
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         for (int c = 0; c < PB_COMPS; c++) begin
            if ({1'b0, raddr[8*c +: 8]} < DEPTH_L)
               rdata_d[8*c +: 8] = mem_q[raddr[8*c +: 8]];
            else
               rdata_d[8*c +: 8] = 8'h00;
`ifdef PIXEL_IN_BUFFER_BYPASS_EN
            // Forward the byte being written this cycle; lane order
            // matches the array write so the same lane wins.
            for (int k = 0; k < PB_LANES; k++) begin
               if (we[k] && (waddr[8*k +: 8] == raddr[8*c +: 8]))
                  rdata_d[8*c +: 8] = wdata[8*k +: 8];
            end
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/pixel_in_buffer.sv
// Input pixel buffer between the AHB/DMA read path and the rotation core.
// Holds one 64-pixel RGB tile and tracks its fill/drain status.
// Ports: I_PB_HCLK, I_PB_HRESET_N (sync, active-low), write beat
//   (WR_EN, WDATA, ADDR0..3), read request (RD_EN, ADDRR/G/B), CLEAR;
//   outputs RDATA_R/G/B, RD_VALID, FULL, EMPTY, OVERFLOW, ADDR_ERR.
// Build option PIXEL_IN_BUFFER_BYPASS_EN: same-cycle read returns new byte.
module pixel_in_buffer
   import pixel_in_buffer_pkg::*;
#(
   parameter int P_DEPTH  = PB_DEPTH_DEF,
   parameter int P_PIXELS = PB_PIXELS_DEF
) (
   input  logic        I_PB_HCLK,
   input  logic        I_PB_HRESET_N,
   input  logic        I_PB_WR_EN,
   input  logic [31:0] I_PB_WDATA,
   input  logic [7:0]  I_PB_ADDR0,
   input  logic [7:0]  I_PB_ADDR1,
   input  logic [7:0]  I_PB_ADDR2,
   input  logic [7:0]  I_PB_ADDR3,
   input  logic        I_PB_RD_EN,
   input  logic [7:0]  I_PB_ADDRR,
   input  logic [7:0]  I_PB_ADDRG,
   input  logic [7:0]  I_PB_ADDRB,
   input  logic        I_PB_CLEAR,
   output logic [7:0]  O_PB_RDATA_R,
   output logic [7:0]  O_PB_RDATA_G,
   output logic [7:0]  O_PB_RDATA_B,
   output logic        O_PB_RD_VALID,
   output logic        O_PB_FULL,
   output logic        O_PB_EMPTY,
   output logic        O_PB_OVERFLOW,
   output logic        O_PB_ADDR_ERR
);

   localparam logic [8:0] DEPTH_L = 9'(P_DEPTH);
   localparam logic [5:0] WORDS_L = 6'(P_DEPTH / PB_LANES);
   localparam logic [6:0] PIX_L   = 7'(P_PIXELS);

   pb_state_e   state_d, state_q;
   logic [5:0]  wr_words_d, wr_words_q;
   logic [6:0]  rd_pix_d, rd_pix_q;
   logic        overflow_d, overflow_q;
   logic        addr_err_d, addr_err_q;
   logic        rd_valid_d, rd_valid_q;

   logic [31:0] waddr;
   logic [23:0] raddr;
   logic [23:0] rdata;
   logic [3:0]  lane_ok;
   logic [2:0]  comp_ok;
   logic [3:0]  mem_we;
   logic        wr_ok;
   logic        addr_bad;

   assign waddr = {I_PB_ADDR3, I_PB_ADDR2, I_PB_ADDR1, I_PB_ADDR0};
   assign raddr = {I_PB_ADDRB, I_PB_ADDRG, I_PB_ADDRR};

   always_comb begin
      for (int k = 0; k < PB_LANES; k++)
         lane_ok[k] = ({1'b0, waddr[8*k +: 8]} < DEPTH_L);
      for (int c = 0; c < PB_COMPS; c++)
         comp_ok[c] = ({1'b0, raddr[8*c +: 8]} < DEPTH_L);
   end

   assign addr_bad = (I_PB_WR_EN && !(&lane_ok)) ||
                     (I_PB_RD_EN && !(&comp_ok));

   // A write during CLEAR is stored but never counted.
   assign mem_we = {PB_LANES{I_PB_WR_EN && (wr_ok || I_PB_CLEAR)}} & lane_ok;

   always_comb begin
      state_d    = state_q;
      wr_words_d = wr_words_q;
      rd_pix_d   = rd_pix_q;
      overflow_d = overflow_q;
      addr_err_d = addr_err_q | addr_bad;
      rd_valid_d = I_PB_RD_EN;
      wr_ok      = 1'b0;

      unique case (state_q)
         S_EMPTY, S_FILL: begin
            if (I_PB_WR_EN) begin
               wr_ok      = 1'b1;
               wr_words_d = wr_words_q + 6'd1;
               state_d    = (wr_words_d == WORDS_L) ? S_FULL : S_FILL;
            end
         end
         S_FULL, S_DRAIN: begin
            if (I_PB_RD_EN) begin
               rd_pix_d = rd_pix_q + 7'd1;
               state_d  = S_DRAIN;
            end
            if (I_PB_RD_EN && (rd_pix_d == PIX_L)) begin
               // Drain completes first; a same-cycle write opens the next tile.
               rd_pix_d   = '0;
               wr_words_d = '0;
               state_d    = S_EMPTY;
               if (I_PB_WR_EN) begin
                  wr_ok      = 1'b1;
                  wr_words_d = 6'd1;
                  state_d    = S_FILL;
               end
            end else if (I_PB_WR_EN) begin
               overflow_d = 1'b1;
            end
         end
      endcase

      if (I_PB_CLEAR) begin
         state_d    = S_EMPTY;
         wr_words_d = '0;
         rd_pix_d   = '0;
         overflow_d = 1'b0;
         addr_err_d = 1'b0;
      end
   end

   always_ff @(posedge I_PB_HCLK) begin
      if (!I_PB_HRESET_N) begin
         state_q    <= S_EMPTY;
         wr_words_q <= '0;
         rd_pix_q   <= '0;
         overflow_q <= 1'b0;
         addr_err_q <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_words_q <= wr_words_d;
         rd_pix_q   <= rd_pix_d;
         overflow_q <= overflow_d;
         addr_err_q <= addr_err_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   pixel_byte_ram #(
      .P_DEPTH (P_DEPTH)
   ) u_ram (
      .clk   (I_PB_HCLK),
      .rst_n (I_PB_HRESET_N),
      .we    (mem_we),
      .waddr (waddr),
      .wdata (I_PB_WDATA),
      .re    (I_PB_RD_EN),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign O_PB_RDATA_R  = rdata[7:0];
   assign O_PB_RDATA_G  = rdata[15:8];
   assign O_PB_RDATA_B  = rdata[23:16];
   assign O_PB_RD_VALID = rd_valid_q;
   assign O_PB_FULL     = (state_q == S_FULL) || (state_q == S_DRAIN);
   assign O_PB_EMPTY    = (state_q == S_EMPTY);
   assign O_PB_OVERFLOW = overflow_q;
   assign O_PB_ADDR_ERR = addr_err_q;

endmodule

// File: tb/tb_pixel_in_buffer.sv
// Scoreboard bench for pixel_in_buffer: reads push expected RGB into a
// queue, a negedge monitor pops on RD_VALID; status is checked inline.
module tb_pixel_in_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [31:0] wdata;
   logic [7:0]  a0, a1, a2, a3;
   logic        rd_en;
   logic [7:0]  ar, ag, ab;
   logic        clr;
   logic [7:0]  rd_r, rd_g, rd_b;
   logic        rd_valid, full, empty, ovf, aerr;

   int checks = 0;
   int errors = 0;
   logic [23:0] exp_q[$];
   logic [7:0]  mdl [256];

   always #5 clk = ~clk;

   pixel_in_buffer dut (
      .I_PB_HCLK     (clk),
      .I_PB_HRESET_N (rst_n),
      .I_PB_WR_EN    (wr_en),
      .I_PB_WDATA    (wdata),
      .I_PB_ADDR0    (a0),
      .I_PB_ADDR1    (a1),
      .I_PB_ADDR2    (a2),
      .I_PB_ADDR3    (a3),
      .I_PB_RD_EN    (rd_en),
      .I_PB_ADDRR    (ar),
      .I_PB_ADDRG    (ag),
      .I_PB_ADDRB    (ab),
      .I_PB_CLEAR    (clr),
      .O_PB_RDATA_R  (rd_r),
      .O_PB_RDATA_G  (rd_g),
      .O_PB_RDATA_B  (rd_b),
      .O_PB_RD_VALID (rd_valid),
      .O_PB_FULL     (full),
      .O_PB_EMPTY    (empty),
      .O_PB_OVERFLOW (ovf),
      .O_PB_ADDR_ERR (aerr)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_valid", {8'h0, rd_b, rd_g, rd_r}, 32'hFFFF_FFFF);
         end else begin
            chk("sb_rdata", {8'h0, rd_b, rd_g, rd_r}, {8'h0, exp_q.pop_front()});
         end
      end
   end

   function automatic logic [7:0] exp_byte(input logic [7:0] a);
      return (a < 8'd192) ? mdl[a] : 8'h00;
   endfunction

   task automatic drive(input logic we, input logic [31:0] addrs,
                        input logic [31:0] wd, input logic re,
                        input logic [23:0] raddr, input logic c);
      wr_en = we;
      {a3, a2, a1, a0} = addrs;
      wdata = wd;
      rd_en = re;
      {ab, ag, ar} = raddr;
      clr = c;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      clr = 1'b0;
   endtask

   task automatic rd(input logic [7:0] r, input logic [7:0] g,
                     input logic [7:0] b);
      exp_q.push_back({exp_byte(b), exp_byte(g), exp_byte(r)});
      drive(1'b0, '0, '0, 1'b1, {b, g, r}, 1'b0);
   endtask

   // Writes n consecutive word beats starting at address 0; byte = addr ^ key.
   task automatic fill(input int n, input logic [7:0] key);
      logic [7:0]  b [4];
      logic [31:0] ad;
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < 4; i++) begin
            ad[8*i +: 8] = 8'(4*k + i);
            b[i] = ad[8*i +: 8] ^ key;
            mdl[ad[8*i +: 8]] = b[i];
         end
         drive(1'b1, ad, {b[3], b[2], b[1], b[0]}, 1'b0, '0, 1'b0);
         chk("fill_full", {31'b0, full}, {31'b0, (k == 47)});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0;
      wdata = '0;
      {a0, a1, a2, a3} = '0;
      rd_en = 1'b0;
      {ar, ag, ab} = '0;
      clr = 1'b0;
      for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: reset state
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_full", {31'b0, full}, 32'd0);
      chk("rst_rdata", {8'h0, rd_b, rd_g, rd_r}, 32'd0);
      chk("rst_valid", {31'b0, rd_valid}, 32'd0);
      chk("rst_flags", {30'b0, ovf, aerr}, 32'd0);

      // 2: fill tile, then first read in FULL
      fill(48, 8'h00);
      chk("fill_empty", {31'b0, empty}, 32'd0);

      // 3: overflow beat while FULL must not store
      drive(1'b1, {8'd3, 8'd2, 8'd1, 8'd0}, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
      chk("ovf_set", {31'b0, ovf}, 32'd1);
      chk("ovf_full", {31'b0, full}, 32'd1);
      rd(8'h15, 8'h16, 8'h17);
      for (int i = 0; i < 63; i++) begin
         rd(8'(3*i), 8'(3*i + 1), 8'(3*i + 2));
         chk("drain_empty", {31'b0, empty}, {31'b0, (i == 62)});
      end
      chk("drain_full", {31'b0, full}, 32'd0);
      chk("ovf_sticky", {31'b0, ovf}, 32'd1);

      // 4: same-cycle write/read collision
`ifdef PIXEL_IN_BUFFER_BYPASS_EN
      exp_q.push_back({8'h20, 8'hBB, 8'hAA});
`else
      exp_q.push_back({8'h20, 8'h11, 8'h10});
`endif
      drive(1'b1, {8'h13, 8'h12, 8'h11, 8'h10}, 32'h3322_BBAA,
            1'b1, {8'h20, 8'h11, 8'h10}, 1'b0);
      mdl[8'h10] = 8'hAA;
      mdl[8'h11] = 8'hBB;
      mdl[8'h12] = 8'h22;
      mdl[8'h13] = 8'h33;
      rd(8'h10, 8'h11, 8'h20);
      chk("coll_state", {30'b0, full, empty}, 32'd0);

      // 5: out-of-range lane, other lanes stored; then CLEAR
      drive(1'b1, {8'hC5, 8'h42, 8'h41, 8'h40}, 32'h1122_3344,
            1'b0, '0, 1'b0);
      mdl[8'h40] = 8'h44;
      mdl[8'h41] = 8'h33;
      mdl[8'h42] = 8'h22;
      chk("aerr_set", {31'b0, aerr}, 32'd1);
      rd(8'h40, 8'h41, 8'h42);
      rd(8'hC8, 8'h41, 8'h13);
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
      chk("clr_flags", {30'b0, ovf, aerr}, 32'd0);
      chk("clr_empty", {31'b0, empty}, 32'd1);
      chk("clr_full", {31'b0, full}, 32'd0);

      // 6: reset mid-tile, then refill
      fill(20, 8'hA5);
      chk("part_empty", {31'b0, empty}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("mrst_empty", {31'b0, empty}, 32'd1);
      chk("mrst_rdata", {8'h0, rd_b, rd_g, rd_r}, 32'd0);
      fill(48, 8'h5A);
      chk("refill_full", {31'b0, full}, 32'd1);
      rd(8'h2D, 8'h2E, 8'h2F);
      rd(8'hBF, 8'h00, 8'h80);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
